bcd_mmss_counter: RTL and testbench

- Parametrised four-digit BCD mm:ss counter for the wristwatch stopwatch and timer datapath, clocked by the 1 Hz tick.
- Counts up or down, loads a preset, and can either wrap or stop at the terminal value.
- Supports lap-hold: the display digits freeze while the internal count keeps running.
- Feeds the 7-segment display mux directly and raises a done flag for the alarm/beeper logic.

---
 rtl/bcd_mmss_counter.sv | 119 +++++++++++
 tb/tb_bcd_mmss_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_mmss_counter.sv
//------------------------------------------------------------------------------
// bcd_mmss_counter
// Four-digit BCD mm:ss up/down counter with preset load, wrap/saturate
// terminal handling, sticky done flag and a lap-hold display register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_mmss_counter #(
  parameter int SEC_TENS_MOD = 6,
  parameter int MIN_TENS_MOD = 10,
  parameter bit WRAP         = 1'b1
) (
  input  logic        clk_1Hz,
  input  logic        reset,
  input  logic        en,
  input  logic        dir,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        lap,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic        done,
  output logic        at_zero
);

  // Digit index 0 is seconds-ones, 3 is minutes-tens, matching load_val layout.
  localparam logic [3:0][3:0] DIG_MAX = {4'(MIN_TENS_MOD - 1), 4'd9,
                                         4'(SEC_TENS_MOD - 1), 4'd9};

  logic [3:0][3:0] c_q, c_d;
  logic [3:0][3:0] h_q, h_d;
  logic            done_q, done_d;

  logic [3:0][3:0] w_stepped;
  logic [3:0][3:0] w_load_clamped;
  logic            w_carry;

  // Ripple the carry/borrow across all digits within the single edge; a
  // carry out of the top digit marks the terminal step.
  always_comb begin
    w_stepped = c_q;
    w_carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (!dir) begin
          if (c_q[i] == DIG_MAX[i]) begin
            w_stepped[i] = 4'd0;
          end else begin
            w_stepped[i] = c_q[i] + 4'd1;
            w_carry      = 1'b0;
          end
        end else begin
          if (c_q[i] == 4'd0) begin
            w_stepped[i] = DIG_MAX[i];
          end else begin
            w_stepped[i] = c_q[i] - 4'd1;
            w_carry      = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < 4; i++) begin
      w_load_clamped[i] = (load_val[i*4 +: 4] > DIG_MAX[i]) ? DIG_MAX[i]
                                                            : load_val[i*4 +: 4];
    end
  end

  always_comb begin
    c_d    = c_q;
    done_d = done_q;
    if (reset) begin
      c_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      c_d    = w_load_clamped;
      done_d = 1'b0;
    end else if (en) begin
      if (w_carry) begin
        done_d = 1'b1;
        c_d    = WRAP ? w_stepped : c_q;
      end else begin
        c_d = w_stepped;
      end
    end
  end

  // The display follows the post-edge count unless lap is holding it.
  always_comb begin
    h_d = h_q;
    if (reset) begin
      h_d = '0;
    end else if (!lap) begin
      h_d = c_d;
    end
  end

  always_ff @(posedge clk_1Hz) begin
    c_q    <= c_d;
    h_q    <= h_d;
    done_q <= done_d;
  end

  assign num0    = h_q[0];
  assign num1    = h_q[1];
  assign num2    = h_q[2];
  assign num3    = h_q[3];
  assign done    = done_q;
  assign at_zero = (c_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_bcd_mmss_counter.sv
//------------------------------------------------------------------------------
// tb_bcd_mmss_counter
// Directed vector table plus hand sequences over three parameterisations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_mmss_counter;

  logic        clk_1Hz = 1'b0;
  logic        reset = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0, lap = 1'b0;
  logic [15:0] load_val = '0;

  logic [3:0] d_n0, d_n1, d_n2, d_n3; logic d_done, d_zero;
  logic [3:0] s_n0, s_n1, s_n2, s_n3; logic s_done, s_zero;
  logic [3:0] t_n0, t_n1, t_n2, t_n3; logic t_done, t_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  bcd_mmss_counter u_def (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .lap(lap), .num0(d_n0), .num1(d_n1), .num2(d_n2),
    .num3(d_n3), .done(d_done), .at_zero(d_zero));

  bcd_mmss_counter #(.WRAP(1'b0)) u_sat (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .lap(lap), .num0(s_n0), .num1(s_n1), .num2(s_n2),
    .num3(s_n3), .done(s_done), .at_zero(s_zero));

  bcd_mmss_counter #(.SEC_TENS_MOD(10)) u_s10 (
    .clk_1Hz(clk_1Hz), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .lap(lap), .num0(t_n0), .num1(t_n1), .num2(t_n2),
    .num3(t_n3), .done(t_done), .at_zero(t_zero));

  wire [15:0] d_disp = {d_n3, d_n2, d_n1, d_n0};
  wire [15:0] s_disp = {s_n3, s_n2, s_n1, s_n0};
  wire [15:0] t_disp = {t_n3, t_n2, t_n1, t_n0};

  typedef struct {
    logic        rst, en, dir, load, lap;
    logic [15:0] lv;
    logic [15:0] exp_disp;
    logic        exp_done, exp_zero;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic d, logic l, logic lp,
                              logic [15:0] v, logic [15:0] x, logic xd, logic xz);
    vec_t t;
    t.rst = r; t.en = e; t.dir = d; t.load = l; t.lap = lp; t.lv = v;
    t.exp_disp = x; t.exp_done = xd; t.exp_zero = xz;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One edge with the given inputs; outputs sampled 1 time unit after it.
  task automatic edge_in(input logic r, input logic e, input logic d, input logic l,
                         input logic lp, input logic [15:0] v);
    reset = r; en = e; dir = d; load = l; lap = lp; load_val = v;
    @(posedge clk_1Hz);
    #1;
  endtask

  initial begin
    // Reset and 75 seconds up.
    edge_in(1, 0, 0, 0, 0, 16'h0000);
    check("reset_disp", d_disp, 16'h0000);
    check("reset_done", {15'd0, d_done}, 16'd0);
    check("reset_zero", {15'd0, d_zero}, 16'd1);
    for (int i = 0; i < 75; i++) edge_in(0, 1, 0, 0, 0, 16'h0000);
    check("up75_disp", d_disp, 16'h0115);
    check("up75_done", {15'd0, d_done}, 16'd0);
    check("up75_s10_disp", t_disp, 16'h0075);
    check("up75_sat_disp", s_disp, 16'h0115);

    // Vector table on the default instance.
    tbl.push_back(mk(1,0,0,0,0,16'h0000, 16'h0000,0,1));
    tbl.push_back(mk(0,1,0,1,0,16'h9958, 16'h9958,0,0));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h9959,0,0));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h0000,1,1));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h0001,1,0));
    tbl.push_back(mk(0,1,0,1,0,16'h0A7B, 16'h0959,0,0));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h1000,0,0));
    tbl.push_back(mk(0,1,1,0,0,16'h0000, 16'h0959,0,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0100, 16'h0100,0,0));
    tbl.push_back(mk(0,1,1,0,0,16'h0000, 16'h0059,0,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0000, 16'h0000,0,1));
    tbl.push_back(mk(0,1,1,0,0,16'h0000, 16'h9959,1,0));
    tbl.push_back(mk(0,0,1,0,0,16'h0000, 16'h9959,1,0));
    tbl.push_back(mk(0,0,0,1,0,16'h1234, 16'h1234,0,0));
    tbl.push_back(mk(0,1,0,0,1,16'h0000, 16'h1234,0,0));
    tbl.push_back(mk(0,1,0,0,1,16'h0000, 16'h1234,0,0));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h1237,0,0));
    tbl.push_back(mk(0,1,0,1,1,16'h0500, 16'h1237,0,0));
    tbl.push_back(mk(0,0,0,0,0,16'h0000, 16'h0500,0,0));
    tbl.push_back(mk(0,0,0,1,0,16'h1234, 16'h1234,0,0));
    tbl.push_back(mk(1,1,0,1,1,16'h5555, 16'h0000,0,1));
    tbl.push_back(mk(0,1,0,0,0,16'h0000, 16'h0001,0,0));
    foreach (tbl[k]) begin
      edge_in(tbl[k].rst, tbl[k].en, tbl[k].dir, tbl[k].load, tbl[k].lap, tbl[k].lv);
      check($sformatf("vec%0d_disp", k), d_disp, tbl[k].exp_disp);
      check($sformatf("vec%0d_done", k), {15'd0, d_done}, {15'd0, tbl[k].exp_done});
      check($sformatf("vec%0d_zero", k), {15'd0, d_zero}, {15'd0, tbl[k].exp_zero});
    end

    // Lap hold over 20 edges while the count keeps running.
    edge_in(1, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 10; i++) edge_in(0, 1, 0, 0, 0, 16'h0000);
    check("lap_pre_disp", d_disp, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      edge_in(0, 1, 0, 0, 1, 16'h0000);
      check($sformatf("lap_hold%0d_disp", i), d_disp, 16'h0010);
      check($sformatf("lap_hold%0d_zero", i), {15'd0, d_zero}, 16'd0);
    end
    edge_in(0, 1, 0, 0, 0, 16'h0000);
    check("lap_release_disp", d_disp, 16'h0031);
    check("lap_release_zero", {15'd0, d_zero}, 16'd0);

    // Saturating countdown to 00:00.
    edge_in(0, 1, 1, 1, 0, 16'h0003);
    check("sat_load_disp", s_disp, 16'h0003);
    edge_in(0, 1, 1, 0, 0, 16'h0000);
    check("sat_dn1_disp", s_disp, 16'h0002);
    edge_in(0, 1, 1, 0, 0, 16'h0000);
    check("sat_dn2_disp", s_disp, 16'h0001);
    check("sat_dn2_done", {15'd0, s_done}, 16'd0);
    edge_in(0, 1, 1, 0, 0, 16'h0000);
    check("sat_dn3_disp", s_disp, 16'h0000);
    check("sat_dn3_zero", {15'd0, s_zero}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      edge_in(0, 1, 1, 0, 0, 16'h0000);
      check($sformatf("sat_hold%0d_disp", i), s_disp, 16'h0000);
      check($sformatf("sat_hold%0d_done", i), {15'd0, s_done}, 16'd1);
    end
    check("wrap_dn_disp", d_disp, 16'h9955);

    // Saturating count up at MAX.
    edge_in(0, 1, 0, 1, 0, 16'h9959);
    check("sat_up_load_done", {15'd0, s_done}, 16'd0);
    edge_in(0, 1, 0, 0, 0, 16'h0000);
    check("sat_up_disp", s_disp, 16'h9959);
    check("sat_up_done", {15'd0, s_done}, 16'd1);

    // Clamp under both seconds-tens moduli.
    edge_in(0, 0, 0, 1, 0, 16'h0A7B);
    check("clamp_def_disp", d_disp, 16'h0959);
    check("clamp_s10_disp", t_disp, 16'h0979);
    edge_in(0, 1, 0, 0, 0, 16'h0000);
    check("s10_up_disp", t_disp, 16'h0980);
    check("def_up_disp", d_disp, 16'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
